// File: rtl/div_seq_if.sv
// Request/response and ALU-borrow signals of the sequential divider.
// ALU operation codes follow the shared EX-stage encoding; the guards let a
// project-wide definition file take precedence when it is compiled first.

`ifndef ALUOp_nop
`define ALUOp_nop  5'b00000
`endif
`ifndef ALUOp_sub
`define ALUOp_sub  5'b00100
`endif
`ifndef ALUOp_sltu
`define ALUOp_sltu 5'b01011
`endif

// Handshake: a request is taken on the rising edge where start=1, the divider
// is idle and flush=0; it stays taken until the single-cycle done pulse, which
// qualifies result. start in any other cycle is ignored, never queued.
interface div_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [4:0]  alu_op;
    logic [31:0] alu_C;
    logic [2:0]  dbg_state;

    modport master (
        output start, op, dividend, divisor, flush, alu_C,
        input  busy, stall, done, result, alu_req, alu_A, alu_B, alu_op, dbg_state
    );

    modport slave (
        input  start, op, dividend, divisor, flush, alu_C,
        output busy, stall, done, result, alu_req, alu_A, alu_B, alu_op, dbg_state
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer. Borrows the EX-stage ALU
// while the pipeline is stalled and runs restoring division, one sltu/sub
// pair per quotient bit, with sign handling by ALU negation before and after.
module div_seq (
    input  logic     clk,
    input  logic     rstn,
    div_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_CMP   = 3'd3,
        S_SUB   = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] r_q, r_d;          // partial remainder
    logic [31:0] q_q, q_d;          // dividend shifting out, quotient shifting in
    logic [31:0] d_q, d_d;          // divisor magnitude
    logic [31:0] result_q, result_d;
    logic        t_q, t_d;          // bit 32 of the shifted partial remainder
    logic        lt_q, lt_d;
    logic        sq_q, sq_d;
    logic        sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        alu_req_q, alu_req_d;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic        accept;
    logic        op_signed;
    logic        fix_neg;
    logic [31:0] fix_val;

    assign accept    = bus.start & ~bus.flush & (state_q == S_IDLE);
    assign op_signed = ~op_q[0];
    assign fix_neg   = op_q[1] ? sr_q : sq_q;
    assign fix_val   = op_q[1] ? r_q : q_q;

    // ALU operand/op selection for the current step; zero/nop outside NEG_A..FIX
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = `ALUOp_nop;
        case (state_q)
            S_NEG_A: if (op_signed & q_q[31]) begin
                alu_b  = q_q;
                alu_op = `ALUOp_sub;
            end
            S_NEG_B: if (op_signed & d_q[31]) begin
                alu_b  = d_q;
                alu_op = `ALUOp_sub;
            end
            S_CMP: begin
                alu_a  = {r_q[30:0], q_q[31]};
                alu_b  = d_q;
                alu_op = `ALUOp_sltu;
            end
            S_SUB: begin
                alu_a  = r_q;
                alu_b  = d_q;
                alu_op = `ALUOp_sub;
            end
            S_FIX: if (fix_neg) begin
                alu_b  = fix_val;
                alu_op = `ALUOp_sub;
            end
            default: ;
        endcase
    end

    // Next-state and datapath update; flush overrides everything and keeps result
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        result_d = result_q;
        t_d      = t_q;
        lt_d     = lt_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d  = bus.op;
                q_d   = bus.dividend;
                d_d   = bus.divisor;
                r_d   = '0;
                t_d   = 1'b0;
                lt_d  = 1'b0;
                sq_d  = ~bus.op[0] & (bus.dividend[31] ^ bus.divisor[31]);
                sr_d  = ~bus.op[0] & bus.dividend[31];
                cnt_d = 5'd31;
                if (bus.divisor == 32'd0) begin
                    result_d = bus.op[1] ? bus.dividend : 32'hFFFF_FFFF;
                    state_d  = S_DONE;
                end else if (~bus.op[0] && bus.dividend == 32'h8000_0000 &&
                             bus.divisor == 32'hFFFF_FFFF) begin
                    result_d = bus.op[1] ? 32'd0 : 32'h8000_0000;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_NEG_A;
                end
            end
            S_NEG_A: begin
                if (op_signed & q_q[31]) q_d = bus.alu_C;
                r_d     = '0;
                state_d = S_NEG_B;
            end
            S_NEG_B: begin
                if (op_signed & d_q[31]) d_d = bus.alu_C;
                state_d = S_CMP;
            end
            S_CMP: begin
                lt_d    = bus.alu_C[0];
                r_d     = alu_a;
                t_d     = r_q[31];
                q_d     = {q_q[30:0], 1'b0};
                state_d = S_SUB;
            end
            S_SUB: begin
                // A shifted value of 2^32 or more is always >= D; the low 32
                // bits of the subtraction are then still exact.
                if (t_q | ~lt_q) begin
                    r_d    = bus.alu_C;
                    q_d[0] = 1'b1;
                end
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = S_CMP;
                end
            end
            S_FIX: begin
                result_d = fix_neg ? bus.alu_C : fix_val;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // Registered status outputs follow the next state
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        alu_req_d = (state_d == S_NEG_A) || (state_d == S_NEG_B) || (state_d == S_CMP) ||
                    (state_d == S_SUB) || (state_d == S_FIX);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            result_q  <= '0;
            t_q       <= 1'b0;
            lt_q      <= 1'b0;
            sq_q      <= 1'b0;
            sr_q      <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            result_q  <= result_d;
            t_q       <= t_d;
            lt_q      <= lt_d;
            sq_q      <= sq_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.alu_req   = alu_req_q;
    assign bus.stall     = accept | alu_req_q;
    assign bus.alu_A     = alu_a;
    assign bus.alu_B     = alu_b;
    assign bus.alu_op    = alu_op;
    assign bus.dbg_state = state_q;

endmodule
